// File: rtl/ahb_lite_slave_mem.sv
// AHB-lite subordinate over a word-organised memory; byte/half/word access, two-cycle ERROR response.
// Data phase lasts 1 cycle, or WAIT_STATES+1 when built with AHB_SLV_WAIT_EN; HREADYOUT low stretches it.
module ahb_lite_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * 4);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                  state_q;
  logic                    hreadyout_q;
  logic                    hresp_q;
  logic [DATA_WIDTH-1:0]   hrdata_q;
  logic                    write_q;
  logic [1:0]              size_q;
  logic [1:0]              lane_q;
  logic [IDX_W-1:0]        idx_q;
`ifdef AHB_SLV_WAIT_EN
  logic [3:0]              cnt_q;
`endif

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                    accept;
  logic                    req_err;
  logic [IDX_W-1:0]        req_idx;
  logic [LANES-1:0]        be;
  logic                    commit;
  logic [DATA_WIDTH-1:0]   wmerge;
  logic [DATA_WIDTH-1:0]   fwd_rdata;
  logic                    unused_ok;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'd0:    lane_mask = 4'b0001 << lane;
      2'd1:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign accept  = HSEL && HREADY && HTRANS[1];
  assign req_idx = HADDR[IDX_W+1:2];
  assign req_err = (HSIZE > 3'd2)
                || (HSIZE == 3'd1 && HADDR[0])
                || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                || ({1'b0, HADDR} >= MEM_BYTES);

  assign be     = lane_mask(size_q, lane_q);
  assign commit = (state_q == S_DATA) && write_q;

  always_comb begin
    wmerge = mem_q[idx_q];
    for (int b = 0; b < LANES; b++) begin
      if (be[b]) wmerge[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  // A read accepted on the same edge a write commits to that word must see the new bytes.
  assign fwd_rdata = (commit && (idx_q == req_idx)) ? wmerge : mem_q[req_idx];

  always_ff @(posedge HCLK) begin
    if (commit && !HRESET) mem_q[idx_q] <= wmerge;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      lane_q      <= 2'd0;
      idx_q       <= '0;
`ifdef AHB_SLV_WAIT_EN
      cnt_q       <= 4'd0;
`endif
    end else begin
      case (state_q)
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
`ifdef AHB_SLV_WAIT_EN
        S_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q     <= S_DATA;
            hreadyout_q <= 1'b1;
            cnt_q       <= 4'd0;
            if (!write_q) hrdata_q <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        default: begin
          // IDLE, DATA and ERR2 all accept the next pipelined address phase.
          if (accept) begin
            write_q <= HWRITE;
            size_q  <= HSIZE[1:0];
            lane_q  <= HADDR[1:0];
            idx_q   <= req_idx;
            if (req_err) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end
`ifdef AHB_SLV_WAIT_EN
            else if (WAIT_STATES != 0) begin
              state_q     <= S_WAIT;
              cnt_q       <= 4'(WAIT_STATES);
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b0;
            end
`endif
            else begin
              state_q     <= S_DATA;
              hreadyout_q <= 1'b1;
              hresp_q     <= 1'b0;
              if (!HWRITE) hrdata_q <= fwd_rdata;
            end
          end else begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;

`ifdef AHB_SLV_WAIT_EN
  assign unused_ok = ^{HBURST, HTRANS[0]};
`else
  assign unused_ok = ^{HBURST, HTRANS[0], 4'(WAIT_STATES)};
`endif

endmodule
